usb_report_buffer: RTL and testbench
====================================

USB_REPORT_BUFFER -- requirements
Module: usb_report_buffer

Interface
REQ-001 Parameter MAX_BYTES, default 8, maximum payload bytes per report (1..64).
REQ-002 Parameter CRC_BYTES, default 2, trailing bytes per packet stripped as CRC16 (0..2).
REQ-003 Parameter DEPTH, default 4, number of report FIFO entries (power of two, >=2).
REQ-004 Parameter LEN_W, default $clog2(MAX_BYTES+1), report length width.
REQ-005 clk  input  1  single clock domain for the block.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 host_connect_i  input  1  device attached; low flushes all stored reports.
REQ-008 new_read_i  input  1  one-cycle pulse at start of each IN transaction; aborts any in-progress capture.
REQ-009 active_in_i  input  1  current transaction is an IN token.
REQ-010 active_read_i  input  1  high while the packet's data bytes are being received.
REQ-011 byte_valid_i  input  1  byte_i carries a received data byte this cycle.
REQ-012 byte_i  input  8  received data byte, in wire order.
REQ-013 report_o  output  MAX_BYTES*8  head-of-FIFO payload, first byte in bits [MAX_BYTES*8-1 -: 8], unused low bytes zero.
REQ-014 report_len_o  output  LEN_W  payload byte count of the head entry.
REQ-015 report_valid_o  output  1  head entry present.
REQ-016 report_ready_i  input  1  consumer accepts the head entry.
REQ-017 drop_cnt_o  output  8  saturating count of discarded packets.
REQ-018 full_o  output  1  FIFO holds DEPTH entries.

Function
REQ-019 Capture FSM states: IDLE, CAPTURE, COMMIT; reset state IDLE.
REQ-020 IDLE->CAPTURE when active_read_i rises with active_in_i high; the byte counter and accumulator are cleared on entry.
REQ-021 In CAPTURE, each cycle with active_read_i && byte_valid_i stores byte_i at index = count and increments count; count saturates at MAX_BYTES+CRC_BYTES+1.
REQ-022 CAPTURE->COMMIT on the first cycle with active_read_i low; COMMIT lasts exactly one cycle, then IDLE.
REQ-023 In COMMIT, payload length L = count-CRC_BYTES; entry pushed if 1<=L<=MAX_BYTES, consisting of the first L bytes left-aligned, remaining bytes zero.
REQ-024 Packets with count<=CRC_BYTES (zero-length/handshake) are discarded silently, without incrementing drop_cnt_o.
REQ-025 Oversize packets (count>MAX_BYTES+CRC_BYTES) are discarded and increment drop_cnt_o.
REQ-026 A push is rejected and increments drop_cnt_o when FIFO is full and no pop occurs in the same cycle; when full with a same-cycle pop, the push is accepted.
REQ-027 drop_cnt_o saturates at 255 and clears only on reset.
REQ-028 new_read_i in any state forces IDLE and discards the partial packet, with no push and no drop count; if coincident with COMMIT, the commit is cancelled.
REQ-029 Pop occurs when report_valid_o && report_ready_i; the next entry appears on the following cycle.
REQ-030 report_valid_o = FIFO non-empty && host_connect_i; report_o/report_len_o are zero when report_valid_o is low.
REQ-031 host_connect_i low empties the FIFO synchronously, forces IDLE, and blocks capture while low.
REQ-032 Write-to-read latency: an entry is visible on report_valid_o in the cycle after COMMIT.
REQ-033 FIFO pointers are log2(DEPTH)+1 bits wide, using the wrap bit for full/empty; ordering is strict FIFO.

Reset
REQ-034 On rst high, immediately: FSM IDLE, count 0, FIFO empty, report_valid_o 0, report_o 0, report_len_o 0, full_o 0, drop_cnt_o 0.
REQ-035 rst asserted mid-capture or mid-pop discards all state; no entry survives reset.

Verification
REQ-036 Defaults; 5-byte IN packet 0x01,0x02,0x03,0xAA,0xBB -> one entry, report_len_o=3, report_o=0x010203_0000000000.
REQ-037 10-byte IN packet (MAX_BYTES=8) -> entry len 8 holding the first 8 bytes; 11-byte packet -> no entry, drop_cnt_o=1.
REQ-038 5 valid packets with report_ready_i=0 (DEPTH=4) -> full_o=1, 4 entries, drop_cnt_o=1; drained in order, matching packets 1..4.
REQ-039 2-byte packet (CRC only) -> no entry, drop_cnt_o unchanged; new_read_i after 3 bytes, then a full 4-byte packet -> only the second packet is stored (len 2).
REQ-040 FIFO full with pop coincident with COMMIT -> push accepted, count stays 4, no drop; host_connect_i low for one cycle -> FIFO empty, report_valid_o=0.
REQ-041 rst pulse mid-capture -> all outputs 0 the same cycle; next packet is captured normally.

Source files
------------

// File: rtl/usb_report_buffer.sv
`default_nettype none
// ============================================================================
// Module   : usb_report_buffer
// Purpose  : Captures IN-packet payloads, strips trailing CRC bytes and queues
//            complete reports in a small FIFO for a downstream consumer.
// Revision : 1.0 - initial release
// ============================================================================
module usb_report_buffer #(
  parameter int MAX_BYTES = 8,
  parameter int CRC_BYTES = 2,
  parameter int DEPTH     = 4,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   host_connect_i,
  input  logic                   new_read_i,
  input  logic                   active_in_i,
  input  logic                   active_read_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_i,
  output logic [MAX_BYTES*8-1:0] report_o,
  output logic [LEN_W-1:0]       report_len_o,
  output logic                   report_valid_o,
  input  logic                   report_ready_i,
  output logic [7:0]             drop_cnt_o,
  output logic                   full_o
);

  localparam int c_DATA_W  = MAX_BYTES * 8;
  localparam int c_CNT_MAX = MAX_BYTES + CRC_BYTES + 1;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_AW      = $clog2(DEPTH);
  localparam int c_PTR_W   = c_AW + 1;

  localparam logic [c_CNT_W-1:0] c_CNT_SAT = c_CNT_W'(c_CNT_MAX);
  localparam logic [c_CNT_W-1:0] c_CRC     = c_CNT_W'(CRC_BYTES);
  localparam logic [c_CNT_W-1:0] c_MAX_PKT = c_CNT_W'(MAX_BYTES + CRC_BYTES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_read_d;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_DATA_W-1:0]  r_acc;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [7:0]           r_drop;
  logic [c_DATA_W-1:0]  r_mem_data [DEPTH];
  logic [LEN_W-1:0]     r_mem_len  [DEPTH];

  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [c_DATA_W-1:0]  w_payload;
  logic [LEN_W-1:0]     w_len;

  assign w_empty        = (r_wr_ptr == r_rd_ptr);
  assign w_full         = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                          (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign report_valid_o = !w_empty && host_connect_i;
  assign w_pop          = report_valid_o && report_ready_i;
  assign report_o       = report_valid_o ? r_mem_data[r_rd_ptr[c_AW-1:0]] : '0;
  assign report_len_o   = report_valid_o ? r_mem_len[r_rd_ptr[c_AW-1:0]] : '0;
  assign full_o         = w_full;
  assign drop_cnt_o     = r_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (active_read_i && !r_read_d && active_in_i) w_next_state = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!active_read_i) w_next_state = S_COMMIT;
      end
      S_COMMIT: begin
        w_next_state = S_IDLE;
        // Handshake-sized packets (CRC only) vanish without counting as a drop.
        if (r_cnt > c_MAX_PKT)        w_drop = 1'b1;
        else if (r_cnt > c_CRC) begin
          if (w_full && !w_pop)       w_drop = 1'b1;
          else                        w_push = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    if (new_read_i || !host_connect_i) begin
      w_next_state = S_IDLE;
      w_push       = 1'b0;
      w_drop       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_d <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
    end else begin
      r_read_d <= active_read_i;
      if (r_state == S_IDLE && w_next_state == S_CAPTURE) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (r_state == S_CAPTURE && active_read_i && byte_valid_i) begin
        for (int i = 0; i < MAX_BYTES; i++) begin
          if (r_cnt == c_CNT_W'(i)) r_acc[(MAX_BYTES-1-i)*8 +: 8] <= byte_i;
        end
        if (r_cnt != c_CNT_SAT) r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  // Keep only the first (count - CRC) bytes; the accumulator may hold CRC bytes.
  always_comb begin
    w_payload = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (c_CNT_W'(i + CRC_BYTES) < r_cnt)
        w_payload[(MAX_BYTES-1-i)*8 +: 8] = r_acc[(MAX_BYTES-1-i)*8 +: 8];
    end
  end

  assign w_len = LEN_W'(r_cnt - c_CRC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_drop   <= '0;
    end else begin
      if (!host_connect_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr[c_AW-1:0]] <= w_payload;
      r_mem_len[r_wr_ptr[c_AW-1:0]]  <= w_len;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_report_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_report_buffer
// Purpose  : Directed bench for usb_report_buffer with a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_report_buffer;

  localparam int MAX_BYTES = 8;
  localparam int CRC_BYTES = 2;
  localparam int DEPTH     = 4;
  localparam int LEN_W     = $clog2(MAX_BYTES + 1);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   host_connect_i = 1'b1;
  logic                   new_read_i = 1'b0;
  logic                   active_in_i = 1'b0;
  logic                   active_read_i = 1'b0;
  logic                   byte_valid_i = 1'b0;
  logic [7:0]             byte_i = 8'h00;
  logic [MAX_BYTES*8-1:0] report_o;
  logic [LEN_W-1:0]       report_len_o;
  logic                   report_valid_o;
  logic                   report_ready_i = 1'b0;
  logic [7:0]             drop_cnt_o;
  logic                   full_o;

  usb_report_buffer #(
    .MAX_BYTES(MAX_BYTES), .CRC_BYTES(CRC_BYTES), .DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .host_connect_i(host_connect_i), .new_read_i(new_read_i),
    .active_in_i(active_in_i), .active_read_i(active_read_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .report_o(report_o),
    .report_len_o(report_len_o), .report_valid_o(report_valid_o),
    .report_ready_i(report_ready_i), .drop_cnt_o(drop_cnt_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int          len;
  } ent_t;

  ent_t       m_q[$];
  logic [7:0] m_bytes[$];
  int         m_drop = 0;
  bit         m_cap = 1'b0;
  bit         m_commit = 1'b0;
  bit         m_prev_read = 1'b0;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] pkt [0:15];

  // Reference: packets are collected as byte lists and judged whole when they end.
  function automatic void model_commit(bit pop, bit was_full);
    int   n;
    int   l;
    ent_t e;
    n = m_bytes.size();
    l = n - CRC_BYTES;
    if (n <= CRC_BYTES) begin
    end else if (n > MAX_BYTES + CRC_BYTES || (was_full && !pop)) begin
      if (m_drop < 255) m_drop++;
    end else begin
      e.data = '0;
      for (int i = 0; i < l; i++) e.data[63-8*i -: 8] = m_bytes[i];
      e.len = l;
      m_q.push_back(e);
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_bytes.delete();
        m_drop = 0;
        m_cap = 1'b0;
        m_commit = 1'b0;
        m_prev_read = 1'b0;
      end else begin
        bit pop, was_full, ending;
        pop      = (m_q.size() != 0) && host_connect_i && report_ready_i;
        was_full = (m_q.size() == DEPTH);
        ending   = m_commit;
        m_commit = 1'b0;
        if (!host_connect_i) begin
          m_q.delete();
        end else begin
          if (pop) void'(m_q.pop_front());
          if (ending && !new_read_i) model_commit(pop, was_full);
        end
        if (new_read_i || !host_connect_i) begin
          m_cap = 1'b0;
        end else if (m_cap) begin
          if (!active_read_i) begin
            m_cap = 1'b0;
            m_commit = 1'b1;
          end else if (byte_valid_i) begin
            m_bytes.push_back(byte_i);
          end
        end else if (!ending && active_read_i && !m_prev_read && active_in_i) begin
          m_cap = 1'b1;
          m_bytes.delete();
        end
        m_prev_read = active_read_i;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit exp_valid;
    exp_valid = (m_q.size() != 0) && host_connect_i;
    check("model_valid", 64'(report_valid_o), 64'(exp_valid));
    check("model_data", report_o, exp_valid ? m_q[0].data : 64'h0);
    check("model_len", 64'(report_len_o), exp_valid ? 64'(m_q[0].len) : 64'h0);
    check("model_full", 64'(full_o), 64'(m_q.size() == DEPTH));
    check("model_drop", 64'(drop_cnt_o), 64'(m_drop));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int n, input bit abort, input bit pop_at_commit);
    new_read_i = 1'b1; active_read_i = 1'b0; active_in_i = 1'b0; byte_valid_i = 1'b0;
    tick();
    new_read_i = 1'b0; active_in_i = 1'b1; active_read_i = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      byte_valid_i = 1'b1;
      byte_i = pkt[i];
      tick();
    end
    byte_valid_i = 1'b0;
    if (!abort) begin
      active_read_i = 1'b0; active_in_i = 1'b0;
      tick();
      if (pop_at_commit) report_ready_i = 1'b1;
      tick();
      report_ready_i = 1'b0;
    end
  endtask

  task automatic set_seq(input int n, input int base);
    for (int i = 0; i < n; i++) pkt[i] = 8'(base + i);
  endtask

  // Packet k carries k payload bytes k1,k2,.. followed by two CRC bytes.
  task automatic send_k(input int k, input bit pop_at_commit);
    for (int i = 0; i < k; i++) pkt[i] = 8'(k*16 + i + 1);
    pkt[k] = 8'hEE;
    pkt[k+1] = 8'hEE;
    send_pkt(k + 2, 1'b0, pop_at_commit);
  endtask

  task automatic drain(input int n);
    report_ready_i = 1'b1;
    repeat (n) tick();
    report_ready_i = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    check("rst_valid", 64'(report_valid_o), 64'h0);
    check("rst_data", report_o, 64'h0);
    check("rst_len", 64'(report_len_o), 64'h0);
    check("rst_full", 64'(full_o), 64'h0);
    check("rst_drop", 64'(drop_cnt_o), 64'h0);
    rst = 1'b0;
    tick();

    pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h03; pkt[3] = 8'hAA; pkt[4] = 8'hBB;
    send_pkt(5, 1'b0, 1'b0);
    check("p5_valid", 64'(report_valid_o), 64'h1);
    check("p5_len", 64'(report_len_o), 64'd3);
    check("p5_data", report_o, 64'h0102_0300_0000_0000);
    drain(1);

    set_seq(10, 8'h10);
    send_pkt(10, 1'b0, 1'b0);
    check("p10_len", 64'(report_len_o), 64'd8);
    check("p10_data", report_o, 64'h1011_1213_1415_1617);
    drain(1);
    set_seq(11, 8'h20);
    send_pkt(11, 1'b0, 1'b0);
    check("p11_valid", 64'(report_valid_o), 64'h0);
    check("p11_drop", 64'(drop_cnt_o), 64'd1);

    for (int k = 1; k <= 5; k++) send_k(k, 1'b0);
    check("fill_full", 64'(full_o), 64'h1);
    check("fill_drop", 64'(drop_cnt_o), 64'd2);
    check("fill_head_len", 64'(report_len_o), 64'd1);
    check("fill_head_data", report_o, 64'h1100_0000_0000_0000);
    drain(3);
    check("last_len", 64'(report_len_o), 64'd4);
    check("last_data", report_o, 64'h4142_4344_0000_0000);
    drain(1);
    check("drained_valid", 64'(report_valid_o), 64'h0);

    pkt[0] = 8'hC1; pkt[1] = 8'hC2;
    send_pkt(2, 1'b0, 1'b0);
    check("crc_only_valid", 64'(report_valid_o), 64'h0);
    check("crc_only_drop", 64'(drop_cnt_o), 64'd2);

    set_seq(3, 8'h51);
    send_pkt(3, 1'b1, 1'b0);
    set_seq(4, 8'h61);
    send_pkt(4, 1'b0, 1'b0);
    check("abort_valid", 64'(report_valid_o), 64'h1);
    check("abort_len", 64'(report_len_o), 64'd2);
    check("abort_data", report_o, 64'h6162_0000_0000_0000);
    drain(1);
    check("abort_single", 64'(report_valid_o), 64'h0);

    for (int k = 1; k <= 4; k++) send_k(k, 1'b0);
    send_k(3, 1'b1);
    check("popcommit_full", 64'(full_o), 64'h1);
    check("popcommit_drop", 64'(drop_cnt_o), 64'd2);
    check("popcommit_head", report_o, 64'h2122_0000_0000_0000);
    host_connect_i = 1'b0;
    tick();
    check("disc_valid", 64'(report_valid_o), 64'h0);
    check("disc_full", 64'(full_o), 64'h0);
    host_connect_i = 1'b1;
    tick();
    check("reconn_valid", 64'(report_valid_o), 64'h0);

    set_seq(5, 8'h81);
    send_pkt(5, 1'b0, 1'b0);
    set_seq(2, 8'hA1);
    send_pkt(2, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(report_valid_o), 64'h0);
    check("arst_data", report_o, 64'h0);
    check("arst_len", 64'(report_len_o), 64'h0);
    check("arst_full", 64'(full_o), 64'h0);
    check("arst_drop", 64'(drop_cnt_o), 64'h0);
    active_read_i = 1'b0; active_in_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    set_seq(5, 8'h91);
    send_pkt(5, 1'b0, 1'b0);
    check("post_rst_len", 64'(report_len_o), 64'd3);
    check("post_rst_data", report_o, 64'h9192_9300_0000_0000);
    drain(1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
